uart_rx: RTL and testbench

UART receiver paired with `baud_rate_gen`. Samples the serial line using the 16x-oversampled `rxclk_en` strobe and deserialises 8N1 frames, LSB first. Presents each received byte with a ready flag, framing-error and overrun status. Sits between the board RX pin and the host-side byte consumer, in the `clk_50m` domain.

---
 rtl/uart_rx.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver driven by a 16x oversampling strobe from
// baud_rate_gen. Presents each received byte with a sticky ready flag and
// framing-error and overrun status.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> a parity bit is expected between the data bits and the stop
//                bit, and a parity_err output (even parity) is added.
//   undefined -> plain 8N1 framing with no parity_err port.
//
// FSM states
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_IDLE   | line idle, waiting for a low rx_s on a strobe
//   S_START  | counting to the middle of the start bit to reject glitches
//   S_DATA   | sampling data bits at bit centres, LSB first
//   S_PARITY | sampling the parity bit (only with UART_RX_PARITY_EN)
//   S_STOP   | sampling the stop bit, then publishing the byte

module uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk_50m,
   input  logic                 rst,
   input  logic                 rxclk_en,
   input  logic                 rx,
   input  logic                 rdy_clr,
   output logic [DATA_BITS-1:0] data,
   output logic                 rdy,
   output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
   output logic                 overrun,
   output logic                 parity_err
`else
   output logic                 overrun
`endif
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   // Sample point inside the start bit, and the sample point of every later
   // bit (one full bit period after the previous sample).
   localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;
`endif

   state_t               state;
   logic                 rx_meta;
   logic                 rx_s;
   logic [CW-1:0]        sample_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shift_reg;
`ifdef UART_RX_PARITY_EN
   logic                 parity_bit;
`endif

   // Two-flop synchroniser for the asynchronous rx pin; resets to idle-high.
   always_ff @(posedge clk_50m) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // Frame FSM with registered byte and status outputs.
   always_ff @(posedge clk_50m) begin
      if (rst) begin
         state      <= S_IDLE;
         sample_cnt <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         data       <= '0;
         rdy        <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_bit <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         // Host clear; a frame completing in this same cycle overrides it below.
         if (rdy_clr) begin
            rdy     <= 1'b0;
            overrun <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (rxclk_en && !rx_s) begin
                  sample_cnt <= '0;
                  bit_cnt    <= '0;
                  state      <= S_START;
               end
            end

            S_START: begin
               if (rxclk_en) begin
                  if (sample_cnt == CNT_MID) begin
                     sample_cnt <= '0;
                     // A line that is already high again mid start bit was noise.
                     state      <= rx_s ? S_IDLE : S_DATA;
                  end else begin
                     sample_cnt <= sample_cnt + 1'b1;
                  end
               end
            end

            S_DATA: begin
               if (rxclk_en) begin
                  if (sample_cnt == CNT_LAST) begin
                     sample_cnt <= '0;
                     shift_reg  <= {rx_s, shift_reg[DATA_BITS-1:1]};
                     if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                        state   <= S_PARITY;
`else
                        state   <= S_STOP;
`endif
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end else begin
                     sample_cnt <= sample_cnt + 1'b1;
                  end
               end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (rxclk_en) begin
                  if (sample_cnt == CNT_LAST) begin
                     sample_cnt <= '0;
                     parity_bit <= rx_s;
                     state      <= S_STOP;
                  end else begin
                     sample_cnt <= sample_cnt + 1'b1;
                  end
               end
            end
`endif

            S_STOP: begin
               if (rxclk_en) begin
                  if (sample_cnt == CNT_LAST) begin
                     sample_cnt <= '0;
                     data       <= shift_reg;
                     rdy        <= 1'b1;
                     frame_err  <= !rx_s;
                     // An unread byte being replaced is an overrun, unless the
                     // host is acknowledging it in this very cycle.
                     overrun    <= rdy_clr ? 1'b0 : (overrun | rdy);
`ifdef UART_RX_PARITY_EN
                     parity_err <= ^{shift_reg, parity_bit};
`endif
                     // Back to idle at once so a back-to-back start bit is seen
                     // on the next strobe.
                     state      <= S_IDLE;
                  end else begin
                     sample_cnt <= sample_cnt + 1'b1;
                  end
               end
            end

            default: begin
               state      <= S_IDLE;
               sample_cnt <= '0;
               bit_cnt    <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed frames against a frame-level model of the
// receiver outputs, compared on every falling clock edge, plus literal checks.

module tb_uart_rx;

   localparam int DB = 8;
   localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic          clk_50m = 1'b0;
   logic          rst = 1'b1;
   logic          rxclk_en;
   logic          rx = 1'b1;
   logic          rdy_clr = 1'b0;
   logic [DB-1:0] data;
   logic          rdy;
   logic          frame_err;
   logic          overrun;
`ifdef UART_RX_PARITY_EN
   logic          parity_err;
   logic          m_perr = 1'b0;
`endif

   logic [1:0]    div = 2'd0;

   logic [DB-1:0] m_data = '0;
   logic          m_rdy  = 1'b0;
   logic          m_ferr = 1'b0;
   logic          m_ovr  = 1'b0;
   bit            chk_en = 1'b0;

   int            n_checks = 0;
   int            n_fail = 0;

   uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
      .clk_50m    (clk_50m),
      .rst        (rst),
      .rxclk_en   (rxclk_en),
      .rx         (rx),
      .rdy_clr    (rdy_clr),
      .data       (data),
      .rdy        (rdy),
      .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
      .overrun    (overrun),
      .parity_err (parity_err)
`else
      .overrun    (overrun)
`endif
   );

   always #5 clk_50m = ~clk_50m;

   // One strobe every 4 clocks.
   always @(posedge clk_50m) div <= div + 2'd1;
   assign rxclk_en = (div == 2'd3);

   // Continuous comparison of the DUT outputs against the model.
   always @(negedge clk_50m) begin
      if (chk_en) begin
         n_checks++;
         if (data !== m_data || rdy !== m_rdy || frame_err !== m_ferr || overrun !== m_ovr
`ifdef UART_RX_PARITY_EN
             || parity_err !== m_perr
`endif
            ) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t got data=%h rdy=%b ferr=%b ovr=%b want data=%h rdy=%b ferr=%b ovr=%b",
                     $time, data, rdy, frame_err, overrun, m_data, m_rdy, m_ferr, m_ovr);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic m_reset();
      m_data = '0;
      m_rdy  = 1'b0;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
`ifdef UART_RX_PARITY_EN
      m_perr = 1'b0;
`endif
   endtask

   // Frame-level effect of one completed frame.
   task automatic m_complete(input logic [7:0] b, input logic stop, input logic pbit, input bit clr);
      m_ovr  = clr ? 1'b0 : (m_ovr | m_rdy);
      m_rdy  = 1'b1;
      m_data = b;
      m_ferr = ~stop;
`ifdef UART_RX_PARITY_EN
      m_perr = ^{b, pbit};
`else
      if (pbit === 1'bx) m_ferr = ~stop;
`endif
   endtask

   // Returns 1 time unit after the next clock edge that carries a strobe.
   task automatic next_strobe();
      do @(posedge clk_50m); while (rxclk_en !== 1'b1);
      #1;
   endtask

   task automatic pulse_clr();
      rdy_clr = 1'b1;
      @(posedge clk_50m);
      #1;
      rdy_clr = 1'b0;
      m_rdy = 1'b0;
      m_ovr = 1'b0;
   endtask

   // Drives one frame aligned to a strobe (S0). The start edge is seen on
   // strobe 1, mid start bit is strobe 9, and each later bit is sampled 16
   // strobes after the previous one, so the stop bit is sampled on strobe
   // 9 + 16*(frame bits after start). Optional rdy_clr on that exact cycle,
   // optional abort after abort_at strobes.
   task automatic send_frame(input logic [7:0] b, input logic stop, input logic pbit,
                             input bit clr, input int gap, input int abort_at);
      logic [11:0] bits;
      int nb;
      int done_idx;
      int s;
      nb = 2 + DB + PB;
      done_idx = 9 + OS * (nb - 1);
      bits = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < DB; i++) bits[1 + i] = b[i];
      if (PB == 1) bits[1 + DB] = pbit;
      bits[nb - 1] = stop;
      next_strobe();
      s = 0;
      for (int j = 0; j < nb; j++) begin
         rx = bits[j];
         for (int k = 0; k < OS; k++) begin
            if (abort_at != 0 && s == abort_at) return;
            if (clr && s + 1 == done_idx) begin
               do @(negedge clk_50m); while (rxclk_en !== 1'b1);
               rdy_clr = 1'b1;
            end
            next_strobe();
            s++;
            if (s == done_idx) begin
               rdy_clr = 1'b0;
               m_complete(b, stop, pbit, clr);
            end
         end
      end
      rx = 1'b1;
      repeat (gap) next_strobe();
   endtask

   initial begin
      m_reset();
      repeat (4) @(posedge clk_50m);
      #1;
      check("reset_data", data, 8'h00);
      check("reset_rdy", {7'd0, rdy}, 8'h00);
      check("reset_ferr", {7'd0, frame_err}, 8'h00);
      check("reset_ovr", {7'd0, overrun}, 8'h00);
      rst = 1'b0;
      chk_en = 1'b1;
      repeat (8) next_strobe();

      send_frame(8'h55, 1'b1, 1'b0, 1'b0, 16, 0);
      check("f55_data", data, 8'h55);
      check("f55_rdy", {7'd0, rdy}, 8'h01);
      check("f55_ferr", {7'd0, frame_err}, 8'h00);
      check("f55_ovr", {7'd0, overrun}, 8'h00);

      next_strobe();
      rx = 1'b0;
      repeat (4) next_strobe();
      rx = 1'b1;
      repeat (24) next_strobe();
      check("glitch_data", data, 8'h55);
      check("glitch_rdy", {7'd0, rdy}, 8'h01);
      pulse_clr();
      check("clr_rdy", {7'd0, rdy}, 8'h00);

      send_frame(8'hA3, 1'b0, 1'b0, 1'b0, 16, 0);
      check("fA3_data", data, 8'hA3);
      check("fA3_ferr", {7'd0, frame_err}, 8'h01);
      check("fA3_rdy", {7'd0, rdy}, 8'h01);
      send_frame(8'h10, 1'b1, 1'b1, 1'b0, 16, 0);
      check("f10_data", data, 8'h10);
      check("f10_ferr", {7'd0, frame_err}, 8'h00);
      pulse_clr();

      send_frame(8'h01, 1'b1, 1'b1, 1'b0, 0, 0);
      send_frame(8'h80, 1'b1, 1'b1, 1'b0, 16, 0);
      check("b2b_data", data, 8'h80);
      check("b2b_ovr", {7'd0, overrun}, 8'h01);
      check("b2b_rdy", {7'd0, rdy}, 8'h01);
      pulse_clr();
      check("b2b_clr_rdy", {7'd0, rdy}, 8'h00);
      check("b2b_clr_ovr", {7'd0, overrun}, 8'h00);

      send_frame(8'h11, 1'b1, 1'b0, 1'b0, 16, 0);
      send_frame(8'h7E, 1'b1, 1'b0, 1'b1, 16, 0);
      check("f7E_data", data, 8'h7E);
      check("f7E_rdy", {7'd0, rdy}, 8'h01);
      check("f7E_ovr", {7'd0, overrun}, 8'h00);

      send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 0, 72);
      rst = 1'b1;
      @(posedge clk_50m);
      #1;
      m_reset();
      check("midrst_data", data, 8'h00);
      check("midrst_rdy", {7'd0, rdy}, 8'h00);
      check("midrst_ferr", {7'd0, frame_err}, 8'h00);
      rx = 1'b1;
      repeat (3) @(posedge clk_50m);
      #1;
      rst = 1'b0;
      repeat (32) next_strobe();
      check("post_rst_rdy", {7'd0, rdy}, 8'h00);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 16, 0);
      check("f3C_data", data, 8'h3C);
      check("f3C_rdy", {7'd0, rdy}, 8'h01);
      check("f3C_ovr", {7'd0, overrun}, 8'h00);

`ifdef UART_RX_PARITY_EN
      pulse_clr();
      send_frame(8'h07, 1'b1, 1'b0, 1'b0, 16, 0);
      check("par0_err", {7'd0, parity_err}, 8'h01);
      pulse_clr();
      send_frame(8'h07, 1'b1, 1'b1, 1'b0, 16, 0);
      check("par1_err", {7'd0, parity_err}, 8'h00);
      check("par1_data", data, 8'h07);
`endif

      repeat (4) @(posedge clk_50m);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
